// File: rtl/ibex_register_file_fpga_mp.sv
// Integer register file for the ID stage: two combinational read ports, write port A plus
// optional port B, optional write-to-read bypass, and a zeroing walk after every reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// StInit  | walk writes WordZeroVal to words 1..NumWords-1, reads give 0
// StRun   | normal operation, init_done_o=1, terminal until reset
module ibex_register_file_fpga_mp #(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter bit                   DualWrite   = 1'b0,
   parameter bit                   BypassEn    = 1'b0,
   parameter bit                   WrenCheck   = 1'b0,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [4:0]           raddr_a_i,
   output logic [DataWidth-1:0] rdata_a_o,
   input  logic [4:0]           raddr_b_i,
   output logic [DataWidth-1:0] rdata_b_o,
   input  logic [4:0]           waddr_a_i,
   input  logic [DataWidth-1:0] wdata_a_i,
   input  logic                 we_a_i,
   input  logic [4:0]           waddr_b_i,
   input  logic [DataWidth-1:0] wdata_b_i,
   input  logic                 we_b_i,
   output logic                 init_done_o,
   output logic                 err_o
);

   localparam int unsigned          AddrWidth = RV32E ? 4 : 5;
   localparam int unsigned          NumWords  = 2 ** AddrWidth;
   localparam logic [AddrWidth-1:0] LastIdx   = AddrWidth'(NumWords - 1);

   typedef enum logic {
      StInit = 1'b0,
      StRun  = 1'b1
   } state_e;

   state_e                 state_q;
   logic [AddrWidth-1:0]   cnt_q;
   logic                   err_q;
   logic                   err_d;
   logic [DataWidth-1:0]   mem_q [NumWords];

   logic                   run;
   logic [AddrWidth-1:0]   ra_idx;
   logic [AddrWidth-1:0]   rb_idx;
   logic [AddrWidth-1:0]   wa_idx;
   logic [AddrWidth-1:0]   wb_idx;
   logic                   we_b;
   logic [DataWidth-1:0]   wdata_b;
   logic                   wa_act;
   logic                   wb_act;
   logic [DataWidth-1:0]   rdata_a;
   logic [DataWidth-1:0]   rdata_b;

   assign run    = (state_q == StRun);
   assign ra_idx = raddr_a_i[AddrWidth-1:0];
   assign rb_idx = raddr_b_i[AddrWidth-1:0];
   assign wa_idx = waddr_a_i[AddrWidth-1:0];

   if (DualWrite) begin : g_port_b
      assign wb_idx  = waddr_b_i[AddrWidth-1:0];
      assign we_b    = we_b_i;
      assign wdata_b = wdata_b_i;
   end else begin : g_no_port_b
      logic unused_port_b;
      assign wb_idx        = '0;
      assign we_b          = 1'b0;
      assign wdata_b       = '0;
      assign unused_port_b = ^{waddr_b_i, wdata_b_i, we_b_i};
   end

   if (RV32E) begin : g_rv32e
      logic unused_addr_msb;
      assign unused_addr_msb = ^{raddr_a_i[4], raddr_b_i[4], waddr_a_i[4], waddr_b_i[4]};
   end

   assign wa_act = run & we_a_i & (wa_idx != '0);
   assign wb_act = run & we_b & (wb_idx != '0);

   always_comb begin
      err_d = 1'b0;
      if (WrenCheck) begin
         if (!run && (we_a_i || we_b)) err_d = 1'b1;
         if (wa_act && wb_act && (wa_idx == wb_idx)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StInit;
         cnt_q   <= AddrWidth'(1);
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         case (state_q)
            StInit: begin
               if (cnt_q == LastIdx) state_q <= StRun;
               else                  cnt_q   <= cnt_q + AddrWidth'(1);
            end
            StRun:   state_q <= StRun;
            default: state_q <= StInit;
         endcase
      end
   end

   // Array is deliberately not reset; the walk clears it before any read can see it.
   always_ff @(posedge clk_i) begin
      if (!run) begin
         mem_q[cnt_q] <= WordZeroVal;
      end else begin
         if (wa_act) mem_q[wa_idx] <= wdata_a_i;
         if (wb_act) mem_q[wb_idx] <= wdata_b;
      end
   end

   always_comb begin
      rdata_a = mem_q[ra_idx];
      if (BypassEn) begin
         if (wb_act && (wb_idx == ra_idx))      rdata_a = wdata_b;
         else if (wa_act && (wa_idx == ra_idx)) rdata_a = wdata_a_i;
      end
      if (!run || (ra_idx == '0)) rdata_a = '0;
   end

   always_comb begin
      rdata_b = mem_q[rb_idx];
      if (BypassEn) begin
         if (wb_act && (wb_idx == rb_idx))      rdata_b = wdata_b;
         else if (wa_act && (wa_idx == rb_idx)) rdata_b = wdata_a_i;
      end
      if (!run || (rb_idx == '0)) rdata_b = '0;
   end

   assign rdata_a_o   = rdata_a;
   assign rdata_b_o   = rdata_b;
   assign init_done_o = run;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// Drives two configurations of the register file from one stimulus stream and compares both
// against an array-based reference model of the register file rules.
module tb_ibex_register_file_fpga_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [4:0]  raddr_a, raddr_b, waddr_a, waddr_b;
   logic [31:0] wdata_a, wdata_b;
   logic        we_a, we_b;
   logic [1:0][31:0] rda, rdb;
   logic [1:0]  done, err;

   int total = 0;
   int bad   = 0;

   // d=0: 32 regs, dual write, bypass, error check, zero init
   // d=1: 16 regs (RV32E), single write, no bypass, no error check, nonzero init word
   logic [31:0] mem_m [2][32];
   int          cyc_m [2];
   logic        err_m [2];

   always #5 clk = ~clk;

   ibex_register_file_fpga_mp #(
      .RV32E(1'b0), .DataWidth(32), .DualWrite(1'b1), .BypassEn(1'b1),
      .WrenCheck(1'b1), .WordZeroVal(32'h0)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .raddr_a_i(raddr_a), .rdata_a_o(rda[0]), .raddr_b_i(raddr_b), .rdata_b_o(rdb[0]),
      .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
      .init_done_o(done[0]), .err_o(err[0])
   );

   ibex_register_file_fpga_mp #(
      .RV32E(1'b1), .DataWidth(32), .DualWrite(1'b0), .BypassEn(1'b0),
      .WrenCheck(1'b0), .WordZeroVal(32'h0BAD_F00D)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .raddr_a_i(raddr_a), .rdata_a_o(rda[1]), .raddr_b_i(raddr_b), .rdata_b_o(rdb[1]),
      .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
      .init_done_o(done[1]), .err_o(err[1])
   );

   function automatic int nw(int d);
      return (d == 0) ? 32 : 16;
   endfunction

   function automatic logic [31:0] wzv(int d);
      return (d == 0) ? 32'h0 : 32'h0BAD_F00D;
   endfunction

   function automatic bit m_done(int d);
      return cyc_m[d] >= nw(d) - 1;
   endfunction

   function automatic int idx(int d, logic [4:0] a);
      return int'(a) % nw(d);
   endfunction

   function automatic bit act_a(int d);
      return m_done(d) && we_a && (idx(d, waddr_a) != 0);
   endfunction

   function automatic bit act_b(int d);
      return (d == 0) && m_done(d) && we_b && (idx(d, waddr_b) != 0);
   endfunction

   function automatic logic [31:0] m_rd(int d, logic [4:0] a);
      int i;
      i = idx(d, a);
      if (!m_done(d) || i == 0) return 32'h0;
      if (d == 0 && act_b(d) && idx(d, waddr_b) == i) return wdata_b;
      if (d == 0 && act_a(d) && idx(d, waddr_a) == i) return wdata_a;
      return mem_m[d][i];
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         cyc_m[d] = 0;
         err_m[d] = 1'b0;
         for (int i = 0; i < 32; i++) mem_m[d][i] = wzv(d);
      end
   endtask

   // One rising edge; the model absorbs the inputs held across that edge.
   task automatic tick();
      bit ea, eb, e;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!m_done(d)) begin
            e = (d == 0) && (we_a || we_b);
            cyc_m[d]++;
         end else begin
            ea = act_a(d);
            eb = act_b(d);
            if (ea) mem_m[d][idx(d, waddr_a)] = wdata_a;
            if (eb) mem_m[d][idx(d, waddr_b)] = wdata_b;
            e = (d == 0) && ea && eb && (idx(d, waddr_a) == idx(d, waddr_b));
         end
         err_m[d] = e;
      end
      #1;
   endtask

   task automatic idle_inputs();
      we_a = 1'b0; we_b = 1'b0;
      waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
      raddr_a = '0; raddr_b = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h5555_5555; raddr_a = 5'd4; raddr_b = 5'd1;
      #1 rst_n = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (done[d] !== 1'b0 || err[d] !== 1'b0 || rda[d] !== 32'h0 || rdb[d] !== 32'h0) begin
            bad++;
            $display("FAIL reset d%0d: done=%b err=%b rda=%h rdb=%h want 0/0/0/0",
                     d, done[d], err[d], rda[d], rdb[d]);
         end
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_init_walk();
      for (int k = 0; k < 33; k++) begin
         raddr_a = 5'($urandom); raddr_b = 5'($urandom);
         #2;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (done[d] !== (k >= nw(d) - 1)) begin
               bad++;
               $display("FAIL walk_done d%0d k=%0d: got %b want %b", d, k, done[d], k >= nw(d) - 1);
            end
            total++;
            if (rda[d] !== m_rd(d, raddr_a) || rdb[d] !== m_rd(d, raddr_b)) begin
               bad++;
               $display("FAIL walk_read d%0d k=%0d: rda=%h rdb=%h want %h %h",
                        d, k, rda[d], rdb[d], m_rd(d, raddr_a), m_rd(d, raddr_b));
            end
         end
         tick();
      end
      for (int a = 0; a < 32; a++) begin
         raddr_a = 5'(a); raddr_b = 5'(31 - a);
         #2;
         total++;
         if (rda[0] !== 32'h0 || rdb[0] !== 32'h0) begin
            bad++;
            $display("FAIL init_word d0 a=%0d: rda=%h rdb=%h want 0", a, rda[0], rdb[0]);
         end
         total++;
         if (rda[1] !== ((a % 16 == 0) ? 32'h0 : 32'h0BAD_F00D)) begin
            bad++;
            $display("FAIL init_word d1 a=%0d: rda=%h", a, rda[1]);
         end
         tick();
      end
   endtask

   task automatic test_write_basic();
      idle_inputs();
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF;
      tick();
      idle_inputs();
      raddr_a = 5'd5; raddr_b = 5'd5;
      #2;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (rda[d] !== 32'hDEAD_BEEF || rdb[d] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_x5 d%0d: rda=%h rdb=%h want deadbeef", d, rda[d], rdb[d]);
         end
      end
      we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h0000_1234; raddr_a = 5'd0;
      tick();
      we_a = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (rda[d] !== 32'h0) begin
            bad++;
            $display("FAIL write_x0 d%0d: got %h want 0", d, rda[d]);
         end
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hCAFE_F00D; raddr_a = 5'd7;
      #2;
      total++;
      if (rda[0] !== 32'hCAFE_F00D) begin
         bad++;
         $display("FAIL bypass_on: got %h want cafef00d", rda[0]);
      end
      total++;
      if (rda[1] !== 32'h0BAD_F00D) begin
         bad++;
         $display("FAIL bypass_off_old: got %h want 0badf00d", rda[1]);
      end
      tick();
      we_a = 1'b0;
      #2;
      total++;
      if (rda[1] !== 32'hCAFE_F00D) begin
         bad++;
         $display("FAIL bypass_off_new: got %h want cafef00d", rda[1]);
      end
   endtask

   task automatic test_dual_conflict();
      idle_inputs();
      we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h1111;
      we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h2222;
      raddr_b = 5'd9;
      #2;
      total++;
      if (rdb[0] !== 32'h2222 || err[0] !== 1'b0) begin
         bad++;
         $display("FAIL dual_bypass: rdb=%h err=%b want 2222 0", rdb[0], err[0]);
      end
      tick();
      idle_inputs();
      raddr_a = 5'd9;
      #2;
      total++;
      if (rda[0] !== 32'h2222 || err[0] !== 1'b1) begin
         bad++;
         $display("FAIL dual_conflict d0: rda=%h err=%b want 2222 1", rda[0], err[0]);
      end
      total++;
      if (rda[1] !== 32'h1111 || err[1] !== 1'b0) begin
         bad++;
         $display("FAIL dual_conflict d1: rda=%h err=%b want 1111 0", rda[1], err[1]);
      end
      tick();
      #2;
      total++;
      if (err[0] !== 1'b0) begin
         bad++;
         $display("FAIL dual_err_width: got %b want 0", err[0]);
      end
   endtask

   task automatic test_init_write();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
      we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hAAAA;
      tick();
      idle_inputs();
      #2;
      total++;
      if (err[0] !== 1'b1 || err[1] !== 1'b0) begin
         bad++;
         $display("FAIL init_write_err: err0=%b err1=%b want 1 0", err[0], err[1]);
      end
      tick();
      #2;
      total++;
      if (err[0] !== 1'b0) begin
         bad++;
         $display("FAIL init_err_width: got %b want 0", err[0]);
      end
      while (cyc_m[0] < 31) tick();
      raddr_a = 5'd3;
      #2;
      total++;
      if (rda[0] !== 32'h0 || rda[1] !== 32'h0BAD_F00D) begin
         bad++;
         $display("FAIL init_write_lost: d0=%h d1=%h want 0 0badf00d", rda[0], rda[1]);
      end
      // second reset arrives ten cycles into a fresh walk
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
      for (int k = 0; k < 10; k++) tick();
      rst_n = 1'b0;
      #2;
      total++;
      if (done[0] !== 1'b0 || done[1] !== 1'b0) begin
         bad++;
         $display("FAIL midwalk_reset: done=%b want 00", done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
      for (int k = 0; k < 33; k++) begin
         #2;
         total++;
         if (done[0] !== (k >= 31)) begin
            bad++;
            $display("FAIL rewalk k=%0d: got %b want %b", k, done[0], k >= 31);
         end
         tick();
      end
   endtask

   task automatic test_rv32e_alias();
      idle_inputs();
      we_a = 1'b1; waddr_a = 5'b10011; wdata_a = 32'h55;
      tick();
      idle_inputs();
      raddr_a = 5'd3; raddr_b = 5'd19;
      #2;
      total++;
      if (rda[1] !== 32'h55 || rdb[1] !== 32'h55) begin
         bad++;
         $display("FAIL rv32e_alias: rda=%h rdb=%h want 55 55", rda[1], rdb[1]);
      end
      total++;
      if (rda[0] !== 32'h0 || rdb[0] !== 32'h55) begin
         bad++;
         $display("FAIL rv32_no_alias: rda=%h rdb=%h want 0 55", rda[0], rdb[0]);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            m_reset();
         end
         we_a    = ($urandom_range(0, 2) != 0);
         we_b    = ($urandom_range(0, 2) != 0);
         waddr_a = 5'($urandom);
         waddr_b = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom);
         wdata_a = $urandom;
         wdata_b = $urandom;
         raddr_a = ($urandom_range(0, 2) == 0) ? waddr_a : 5'($urandom);
         raddr_b = ($urandom_range(0, 2) == 0) ? waddr_b : 5'($urandom);
         #2;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (rda[d] !== m_rd(d, raddr_a) || rdb[d] !== m_rd(d, raddr_b)) begin
               bad++;
               $display("FAIL rand_read d%0d n=%0d: rda=%h rdb=%h want %h %h",
                        d, n, rda[d], rdb[d], m_rd(d, raddr_a), m_rd(d, raddr_b));
            end
            total++;
            if (done[d] !== m_done(d) || err[d] !== err_m[d]) begin
               bad++;
               $display("FAIL rand_ctrl d%0d n=%0d: done=%b err=%b want %b %b",
                        d, n, done[d], err[d], m_done(d), err_m[d]);
            end
         end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      m_reset();
      test_reset();
      test_init_walk();
      test_write_basic();
      test_bypass();
      test_dual_conflict();
      test_rv32e_alias();
      test_init_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibex_register_file_fpga_mp.md
Name: ibex_register_file_fpga_mp

Overview:
Parametrised successor of the single-write FPGA register file.
- Adds an optional second write port with defined write priority.
- Adds optional write-to-read bypass.
- Adds a hardware initialisation walk after every reset, so the block no longer relies on an initial block to clear the array.
- Sits in the ID stage as the integer register file; port B serves a second writeback source.

Parameters:
RV32E, 0, 1 = 16 architectural registers (ADDR_WIDTH 4), 0 = 32 registers (ADDR_WIDTH 5)
DataWidth, 32, register word width in bits
DualWrite, 0, 1 = write port B enabled; 0 = port B inputs ignored
BypassEn, 0, 1 = a same-cycle write is forwarded to matching read ports
WrenCheck, 0, 1 = err_o reports illegal or conflicting writes; 0 = err_o tied 0
WordZeroVal, all-zeros, value written to every word by the init walk

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
raddr_a_i  in  5  read address A
rdata_a_o  out  DataWidth  read data A
raddr_b_i  in  5  read address B
rdata_b_o  out  DataWidth  read data B
waddr_a_i  in  5  write address, port A
wdata_a_i  in  DataWidth  write data, port A
we_a_i  in  1  write enable, port A
waddr_b_i  in  5  write address, port B
wdata_b_i  in  DataWidth  write data, port B
we_b_i  in  1  write enable, port B
init_done_o  out  1  1 = init walk complete, array usable
err_o  out  1  registered one-cycle error pulse

Behaviour:
Clock and reset:
- One clock, clk_i.
- Reset rst_ni is asynchronous, active-low.

Addressing:
- NUM_WORDS = 2**ADDR_WIDTH.
- The array index uses the low ADDR_WIDTH address bits only. In RV32E, bit 4 is ignored.
- Index 0 always reads all-zeros. Writes to index 0 are dropped.

FSM, states INIT and RUN:
- Reset: state=INIT, walk counter cnt=1, err_o=0, init_done_o=0. Array contents are not reset.
- INIT: each posedge writes WordZeroVal to mem[cnt].
  - If cnt==NUM_WORDS-1, go to RUN.
  - Otherwise cnt increments.
  - INIT therefore lasts NUM_WORDS-1 cycles (31, or 15 for RV32E).
- RUN: terminal until the next reset. init_done_o=1 in RUN only.
- Reset asserted mid-walk or in RUN returns immediately to INIT with cnt=1. The walk restarts in full.

Reads:
- Combinational, zero-latency.
- While in INIT, rdata_a_o and rdata_b_o are all-zeros regardless of address.
- In RUN, a read returns mem[index], except index 0 returns zero.

Writes (RUN only):
- Port A is active when we_a_i=1 and index!=0.
- Port B is active when DualWrite=1, we_b_i=1 and index!=0.
- Active writes update the array at the posedge.
- Both ports active with the same index: port B wins; port A's write is discarded.
- Writes requested during INIT are dropped.

Bypass:
- Applies only when BypassEn=1, in RUN.
- A read whose index (nonzero) equals an active write index in the same cycle returns that write's data.
- If both ports match, port B's data is returned.
- When BypassEn=0, a read returns the pre-write value in the write cycle and the new value from the next cycle.

err_o (WrenCheck=1):
- Pulses high for exactly one cycle after a posedge at which either:
  - we_a_i or we_b_i (the latter counted only when DualWrite=1) was high during INIT, or
  - both ports were active with the same index in RUN.
- A nonzero-address check is part of the active definition, not an error.
- err_o is 0 in reset.

Unused-signal handling: the upper address bit in RV32E and the port B inputs when DualWrite=0 are sunk to lint-clean unused wires.

Test Plan:
1. Default parameters: release reset, hold all write enables 0 → init_done_o=0 for 31 posedges and 1 after the 31st. Read every address → 0x00000000 (WordZeroVal).
2. RUN: write 0xDEADBEEF to x5 via port A, then read raddr_a=5 and raddr_b=5 the next cycle → both 0xDEADBEEF. Write 0x1234 to x0, then read x0 → 0.
3. BypassEn=1: in one cycle write 0xCAFEF00D to x7 with raddr_a_i=7 → rdata_a_o=0xCAFEF00D in the same cycle. With BypassEn=0 → old value in that cycle, new value the next cycle.
4. DualWrite=1, WrenCheck=1: port A writes 0x1111 and port B writes 0x2222 to x9 in the same cycle → x9 reads 0x2222; err_o high for exactly one cycle after that posedge.
5. WrenCheck=1: assert we_a_i to x3 with 0xAAAA during INIT → the write is lost (x3 reads 0 after the walk); err_o pulses one cycle. Assert reset at walk cycle 10 → init_done_o stays 0 for a further 31 posedges after release.
6. RV32E=1: walk lasts 15 cycles. Write 0x55 to address 5'b10011 → reading address 3 returns 0x55.
